// File: rtl/pe_pkg.sv
// Shared types and arithmetic helpers for the weight-stationary PE.
// Sums are evaluated in a fixed extended width wide enough for any
// supported accumulator plus its carry and a sign guard bit.
package pe_pkg;

    typedef enum logic {
        PE_UNSIGNED = 1'b0,
        PE_SIGNED   = 1'b1
    } pe_mode_e;

    localparam int PE_MAX_ACC_W = 64;
    localparam int PE_EXT_W     = PE_MAX_ACC_W + 2;

    typedef logic signed [PE_EXT_W-1:0] pe_ext_t;

    typedef struct packed {
        logic [PE_MAX_ACC_W-1:0] sum;
        logic                    ovf;
    } pe_sat_res_t;

    // Largest representable accumulator value for a given width and mode.
    function automatic pe_ext_t acc_max(input int accw, input pe_mode_e mode);
        pe_ext_t one;
        one = pe_ext_t'(1);
        if (mode == PE_SIGNED) begin
            return (one <<< (accw - 1)) - one;
        end
        return (one <<< accw) - one;
    endfunction

    // Smallest representable accumulator value for a given width and mode.
    function automatic pe_ext_t acc_min(input int accw, input pe_mode_e mode);
        pe_ext_t one;
        one = pe_ext_t'(1);
        if (mode == PE_SIGNED) begin
            return -(one <<< (accw - 1));
        end
        return '0;
    endfunction

    // Add two pre-extended operands, flag a range violation, and either
    // clamp to the bound or keep the wrapped low bits.
    function automatic pe_sat_res_t sat_add(input pe_ext_t a,
                                            input pe_ext_t b,
                                            input pe_ext_t mx,
                                            input pe_ext_t mn,
                                            input logic    saturate);
        pe_sat_res_t res;
        pe_ext_t     s;
        s       = a + b;
        res.ovf = 1'b0;
        res.sum = s[PE_MAX_ACC_W-1:0];
        if (s > mx) begin
            res.ovf = 1'b1;
            if (saturate) res.sum = mx[PE_MAX_ACC_W-1:0];
        end else if (s < mn) begin
            res.ovf = 1'b1;
            if (saturate) res.sum = mn[PE_MAX_ACC_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_mac_sat.sv
// Combinational multiply-add with optional saturation: sum = in_A*weight + in_B.
// The product is formed at 2*DATAWIDTH bits and widened before the add so
// the carry out of the accumulator range is visible to the overflow check.
module pe_mac_sat #(
    parameter int DATAWIDTH = 8,
    parameter int ACCWIDTH  = 32,
    parameter int SIGNED    = 1,
    parameter int SATURATE  = 1
) (
    input  logic [DATAWIDTH-1:0] i_a,
    input  logic [DATAWIDTH-1:0] i_w,
    input  logic [ACCWIDTH-1:0]  i_b,
    output logic [ACCWIDTH-1:0]  o_sum,
    output logic                 o_ovf
);
    import pe_pkg::*;

    localparam pe_mode_e MODE    = (SIGNED != 0) ? PE_SIGNED : PE_UNSIGNED;
    localparam pe_ext_t  ACC_MAX = acc_max(ACCWIDTH, MODE);
    localparam pe_ext_t  ACC_MIN = acc_min(ACCWIDTH, MODE);
    localparam logic     SAT_EN  = (SATURATE != 0);

    if ((ACCWIDTH < 2 * DATAWIDTH) || (ACCWIDTH > PE_MAX_ACC_W)) begin : g_param_err
        $error("pe_mac_sat: ACCWIDTH must be in [2*DATAWIDTH, 64]");
    end

    pe_ext_t     w_prod_ext;
    pe_ext_t     w_b_ext;
    pe_sat_res_t w_res;
    logic        w_unused_hi;

    if (SIGNED != 0) begin : g_signed
        (* use_dsp = "yes" *) logic signed [2*DATAWIDTH-1:0] w_prod;
        assign w_prod     = $signed(i_a) * $signed(i_w);
        assign w_prod_ext = {{(PE_EXT_W-2*DATAWIDTH){w_prod[2*DATAWIDTH-1]}}, w_prod};
        assign w_b_ext    = {{(PE_EXT_W-ACCWIDTH){i_b[ACCWIDTH-1]}}, i_b};
    end else begin : g_unsigned
        (* use_dsp = "yes" *) logic [2*DATAWIDTH-1:0] w_prod;
        assign w_prod     = i_a * i_w;
        assign w_prod_ext = {{(PE_EXT_W-2*DATAWIDTH){1'b0}}, w_prod};
        assign w_b_ext    = {{(PE_EXT_W-ACCWIDTH){1'b0}}, i_b};
    end

    assign w_res       = sat_add(w_prod_ext, w_b_ext, ACC_MAX, ACC_MIN, SAT_EN);
    assign o_sum       = w_res.sum[ACCWIDTH-1:0];
    assign o_ovf       = w_res.ovf;
    // Upper bits of the fixed-width result are meaningless for narrower accumulators.
    assign w_unused_hi = ^w_res.sum;

endmodule

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary PE with a double-buffered weight: the shadow register
// shifts down the column while the active weight keeps feeding the MAC.
// All outputs are registered; the arithmetic lives in pe_mac_sat.
module pe_ws_dbuf #(
    parameter int DATAWIDTH = 8,
    parameter int ACCWIDTH  = 32,
    parameter int SIGNED    = 1,
    parameter int SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wt_en,
    input  logic [DATAWIDTH-1:0] wt,
    input  logic                 wt_swap,
    input  logic                 valid_in,
    input  logic [DATAWIDTH-1:0] in_A,
    input  logic [ACCWIDTH-1:0]  in_B,
    output logic                 wt_en_out,
    output logic [DATAWIDTH-1:0] wt_out,
    output logic                 valid_out,
    output logic [ACCWIDTH-1:0]  out_D,
    output logic [DATAWIDTH-1:0] out_R,
    output logic                 ovf_out
);
    import pe_pkg::*;

    logic [1:0]           r_rst_sync;
    logic [DATAWIDTH-1:0] r_shadow;
    logic [DATAWIDTH-1:0] r_active;
    logic                 r_wt_en;
    logic [ACCWIDTH-1:0]  r_out_d;
    logic [DATAWIDTH-1:0] r_out_r;
    logic                 r_valid;
    logic                 r_ovf;
    logic                 w_run;
    logic [ACCWIDTH-1:0]  w_sum;
    logic                 w_ovf;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_run = r_rst_sync[1];

    // Shadow loads from the chain; swap copies the pre-edge shadow into active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_active <= '0;
            r_wt_en  <= 1'b0;
        end else if (!w_run) begin
            r_shadow <= '0;
            r_active <= '0;
            r_wt_en  <= 1'b0;
        end else begin
            if (wt_en)   r_shadow <= wt;
            if (wt_swap) r_active <= r_shadow;
            r_wt_en <= wt_en;
        end
    end

    pe_mac_sat #(
        .DATAWIDTH (DATAWIDTH),
        .ACCWIDTH  (ACCWIDTH),
        .SIGNED    (SIGNED),
        .SATURATE  (SATURATE)
    ) u_mac (
        .i_a   (in_A),
        .i_w   (r_active),
        .i_b   (in_B),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    // Capture the MAC result on valid; data holds across gaps, flags drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_d <= '0;
            r_out_r <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (!w_run) begin
            r_out_d <= '0;
            r_out_r <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (valid_in) begin
            r_out_d <= w_sum;
            r_out_r <= in_A;
            r_valid <= 1'b1;
            r_ovf   <= w_ovf;
        end else begin
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end
    end

    assign wt_en_out = r_wt_en;
    assign wt_out    = r_shadow;
    assign valid_out = r_valid;
    assign out_D     = r_out_d;
    assign out_R     = r_out_r;
    assign ovf_out   = r_ovf;

endmodule
